enc_home_ctrl: RTL

Homing and position controller for the incremental encoder on the JA header. It synchronizes raw A/B/Z, decodes quadrature ×4 into a signed position counter, and runs the homing sequence: on request it seeks the Z index, zeroes the position there, and reports homed, fault and error status. It sits beside the encoder input block in `top`, shares the 100 MHz clock and the user reset on BTN0, and feeds status to the LED logic.

---
 rtl/enc_home_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/enc_home_ctrl.sv
// Quadrature x4 position counter with Z-index homing FSM.
// Raw A/B/Z are synchronized, step-decoded into a register stage, then applied to position and state.
module enc_home_ctrl #(
    parameter int POS_W       = 32,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic             I_CLK_100MHZ,
    input  logic             I_RST,
    input  logic             I_ENC_A,
    input  logic             I_ENC_B,
    input  logic             I_ENC_Z,
    input  logic             I_HOME_REQ,
    input  logic             I_ABORT,
    output logic [POS_W-1:0] O_POS,
    output logic [1:0]       O_STATE,
    output logic             O_BUSY,
    output logic             O_HOMED,
    output logic             O_DONE,
    output logic             O_ERR_TIMEOUT,
    output logic             O_ERR_QUAD
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_HOMED = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // Encoder bit order in the pipeline registers: {A, B, Z}.
    logic [2:0]       s1_q, s2_q, prev_q;
    logic [1:0]       prime_q;
    logic             primed;
    logic [1:0]       idx_cur, idx_prev, idx_diff;
    logic             up_q, dn_q, bad_q, zrise_q;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic             accept, zero_pos, done_d, set_to, clr_to;

    assign primed = (prime_q == 2'd3);

    // Gray phase index {B, A^B}: 00->0, 10->1, 11->2, 01->3, so +1 mod 4 is a forward step.
    always_comb begin
        idx_cur  = {s2_q[1], s2_q[2] ^ s2_q[1]};
        idx_prev = {prev_q[1], prev_q[2] ^ prev_q[1]};
        idx_diff = idx_cur - idx_prev;
    end

    always_ff @(posedge I_CLK_100MHZ) begin
        if (I_RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            prime_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            bad_q   <= 1'b0;
            zrise_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge value of its source,
            // which is what makes s1 -> s2 -> prev a real shift chain rather than a single wire.
            s1_q   <= {I_ENC_A, I_ENC_B, I_ENC_Z};
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (!primed) prime_q <= prime_q + 2'd1;
            up_q    <= primed && (idx_diff == 2'd1);
            dn_q    <= primed && (idx_diff == 2'd3);
            bad_q   <= primed && (idx_diff == 2'd2);
            zrise_q <= primed && s2_q[0] && !prev_q[0];
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        state_d  = state_q;
        accept   = 1'b0;
        zero_pos = 1'b0;
        done_d   = 1'b0;
        set_to   = 1'b0;
        clr_to   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!I_ABORT && I_HOME_REQ) begin
                    state_d = ST_SEEK;
                    accept  = 1'b1;
                end
            end
            ST_SEEK: begin
                if (I_ABORT) begin
                    state_d = ST_IDLE;
                end else if (zrise_q) begin
                    state_d  = ST_HOMED;
                    zero_pos = 1'b1;
                    done_d   = 1'b1;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    set_to  = 1'b1;
                end
            end
            ST_HOMED: begin
                if (I_HOME_REQ) begin
                    state_d = ST_SEEK;
                    accept  = 1'b1;
                end
            end
            ST_FAULT: begin
                if (I_ABORT) begin
                    state_d = ST_IDLE;
                    clr_to  = 1'b1;
                end else if (I_HOME_REQ) begin
                    state_d = ST_SEEK;
                    accept  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK_100MHZ) begin
        if (I_RST) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            O_POS         <= '0;
            O_BUSY        <= 1'b0;
            O_HOMED       <= 1'b0;
            O_DONE        <= 1'b0;
            O_ERR_TIMEOUT <= 1'b0;
            O_ERR_QUAD    <= 1'b0;
        end else begin
            state_q <= state_d;
            O_BUSY  <= (state_d == ST_SEEK);
            O_HOMED <= (state_d == ST_HOMED);
            O_DONE  <= done_d;

            // Zeroing on the index discards any step decoded in the same cycle.
            if (zero_pos)  O_POS <= '0;
            else if (up_q) O_POS <= O_POS + POS_W'(1);
            else if (dn_q) O_POS <= O_POS - POS_W'(1);

            if (state_d == ST_SEEK && state_q != ST_SEEK) tmr_q <= '0;
            else if (state_q == ST_SEEK)                  tmr_q <= tmr_q + TMR_W'(1);

            if (set_to)                O_ERR_TIMEOUT <= 1'b1;
            else if (accept || clr_to) O_ERR_TIMEOUT <= 1'b0;

            if (bad_q)       O_ERR_QUAD <= 1'b1;
            else if (accept) O_ERR_QUAD <= 1'b0;
        end
    end

    assign O_STATE = state_q;

endmodule
